// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch (i_*) and load/store (d_*) ports; clk, rst; m_* drive memory; busy = access in flight
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [2:0] LAT = 3'(MEM_LAT);
  state_t state;
  logic [2:0] cnt;
  logic own, last_d, own_we, go, pick_d;
  always_comb begin
    go = state == IDLE && !rst && (i_req || d_req);
    pick_d = d_req && (!i_req || !last_d);
    i_gnt = go && !pick_d;
    d_gnt = go && pick_d;
    m_en = go;
    m_we = d_gnt && d_we;
    m_addr = !go ? '0 : pick_d ? d_addr : i_addr;
    m_wdata = d_gnt ? d_wdata : '0;
    m_wstrb = d_gnt ? d_wstrb : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      own <= 1'b0;
      own_we <= 1'b0;
      last_d <= 1'b1;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          state <= WAIT;
          own <= pick_d;
          last_d <= pick_d;
          own_we <= pick_d && d_we;
          cnt <= 3'd1;
        end
      end else begin
        cnt <= cnt + 3'd1;
        if (cnt == LAT) begin
          state <= IDLE;
          i_rvalid <= !own;
          d_rvalid <= own;
          if (!own) i_rdata <= m_rdata;
          if (own && !own_we) d_rdata <= m_rdata;
        end
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set the cycles from memory enable to m_rdata valid; legal range 1..7.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  instruction-fetch request; held with i_addr until i_gnt.
REQ-005 i_addr  input  32  fetch byte address (the pc).
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  one-cycle pulse; i_rdata holds the fetched instruction.
REQ-008 i_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  datapath load/store request; held with d_we, d_addr, d_wdata and d_wstrb until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_wstrb  input  4  store byte enables.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle pulse; load data is valid, or the store is acknowledged.
REQ-016 d_rdata  output  32  load data.
REQ-017 m_en, m_we  output  1 each  memory access strobe and write enable.
REQ-018 m_addr, m_wdata  output  32 each  memory address and write data; m_wstrb  output  4  memory byte enables.
REQ-019 m_rdata  input  32  memory read data, valid MEM_LAT cycles after m_en.
REQ-020 busy  output  1  high whenever state != IDLE.

Function
REQ-021 The FSM SHALL have two states: IDLE and WAIT. It SHALL also hold a 3-bit counter cnt, a 1-bit owner register own (0 = I, 1 = D) and a 1-bit last_d flag.
REQ-022 In IDLE with at least one request, the block SHALL grant one requester combinationally in that cycle:
- assert that requester's gnt and m_en;
- drive m_addr from the winner's address;
- for D, drive m_we = d_we, m_wdata = d_wdata and m_wstrb = d_wstrb;
- for I, drive m_we = 0 and m_wstrb = 0.
REQ-023 Arbitration SHALL be:
- only one request pending: that request wins;
- both pending: I wins if last_d = 1, otherwise D wins.
REQ-024 On a grant, the block SHALL set own to the winner, set last_d = own, set cnt = 1 and enter WAIT.
REQ-025 In WAIT:
- m_en, m_we, i_gnt and d_gnt SHALL be 0;
- requests SHALL be ignored;
- cnt SHALL increment each cycle.
REQ-026 When cnt == MEM_LAT in WAIT, the block SHALL:
- register m_rdata into i_rdata (own = 0), or into d_rdata (own = 1, d_we = 0 at grant);
- register a one-cycle pulse on the owner's rvalid for the next cycle;
- return to IDLE.
REQ-027 Latency: rvalid SHALL assert exactly MEM_LAT+1 cycles after the gnt cycle.
REQ-028 A new grant SHALL be possible in the same cycle rvalid is high, giving one access per MEM_LAT+1 cycles.
REQ-029 A store SHALL produce a d_rvalid acknowledge at the same latency as a load, and SHALL leave d_rdata unchanged.
REQ-030 i_rvalid and d_rvalid SHALL never be high in the same cycle; i_gnt and d_gnt SHALL never be high in the same cycle.
REQ-031 i_rdata and d_rdata SHALL hold their last captured value between pulses.
REQ-032 Deassertion of a request after its gnt SHALL NOT affect the transaction in flight.

Reset
REQ-033 Under rst, the block SHALL set:
- state = IDLE;
- cnt = 0, own = 0, last_d = 1;
- i_rvalid = d_rvalid = 0;
- i_rdata = d_rdata = 0.
REQ-034 During rst, all gnt and m_* outputs SHALL be 0.
REQ-035 Reset asserted in WAIT SHALL abort the access with no rvalid pulse, and the first grant after reset SHALL follow REQ-023 with last_d = 1.

Verification (MEM_LAT = 2)
REQ-036 Fetch only: i_req at cycle 0, i_addr = 0x0000_0010, memory returns 0x0050_0093 -> i_gnt and m_en at cycle 0, i_rvalid at cycle 3, i_rdata = 0x0050_0093.
REQ-037 Store: d_req, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_wstrb = 0xF -> m_we = 1 with the same values at the gnt cycle; d_rvalid 3 cycles later; d_rdata unchanged.
REQ-038 Simultaneous i_req and d_req held continuously after reset -> grants I, D, I, D at cycles 0, 3, 6, 9, with matching rvalid pulses at 3, 6, 9, 12.
REQ-039 Back-to-back loads: d_req held with addresses 0x200 then 0x204 -> second d_gnt in the same cycle as the first d_rvalid; busy low only in grant cycles.
REQ-040 rst pulse one cycle after a grant -> no rvalid pulse; all outputs at reset values; next simultaneous request granted to I.
REQ-041 Request dropped during WAIT -> rvalid still fires at MEM_LAT+1; no extra grant is issued.
